// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// Requester index names match the arbiter's req_* bit positions.
package rf_arb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam int REQ_WB  = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_EXC = 2;

  // Ceiling log2, never below 1 so a counter or pointer always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker: first set request at or above start_i,
// wrapping back to the lowest index. Callers clear bits they never grant.
module rf_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(start_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i < int'(start_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Arbitrates the single register-file write port: req0 first, round-robin among
// the rest, starved requesters override. Optional statistics via RF_WR_ARB_STATS_EN.
module rf_wr_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int AW           = RF_AW,
  parameter int DW           = RF_DW,
  parameter int STARVE_LIMIT = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_wr,
  output logic [AW-1:0]      rf_addr,
  output logic [DW-1:0]      rf_data,
  output logic               busy
`ifdef RF_WR_ARB_STATS_EN
  ,
  output logic [15:0]        stat_drop_cnt,
  output logic [15:0]        stat_starve_cnt
`endif
);

  localparam int PW = clog2(NREQ);
  localparam int WW = clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wait_q [NREQ];
  logic [WW-1:0]   wait_d [NREQ];
  logic            rf_wr_q, rf_wr_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;

  logic [NREQ-1:0] starvedMask, normalMask;
  logic [NREQ-1:0] starvedPick, normalPick;
  logic [NREQ-1:0] grant;
  logic            viaStarve;
  logic            accepted;
  logic [AW-1:0]   winAddr;
  logic [DW-1:0]   winData;

  always_comb begin
    starvedMask = '0;
    for (int i = 1; i < NREQ; i++) begin
      starvedMask[i] = req_valid[i] && (wait_q[i] == WAIT_MAX);
    end
    normalMask         = req_valid;
    normalMask[REQ_WB] = 1'b0;
  end

  rf_rr_pick #(.N(NREQ), .PW(PW)) u_pickStarved (
    .req_i   (starvedMask),
    .start_i (ptr_q),
    .grant_o (starvedPick)
  );

  rf_rr_pick #(.N(NREQ), .PW(PW)) u_pickNormal (
    .req_i   (normalMask),
    .start_i (ptr_q),
    .grant_o (normalPick)
  );

  // Grant is forced low while reset is held so no handshake completes in reset.
  always_comb begin
    grant     = '0;
    viaStarve = 1'b0;
    if (reset) begin
      if (|starvedMask) begin
        grant     = starvedPick;
        viaStarve = 1'b1;
      end else if (req_valid[REQ_WB]) begin
        grant[REQ_WB] = 1'b1;
      end else begin
        grant = normalPick;
      end
    end
  end

  always_comb begin
    winAddr = '0;
    winData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        winAddr = req_addr[i*AW +: AW];
        winData = req_data[i*DW +: DW];
      end
    end
  end

  // Writes to register 0 are accepted but never reach the port; the port
  // address/data keep their previous values in that case.
  always_comb begin
    accepted  = |grant;
    rf_wr_d   = accepted && (winAddr != '0);
    rf_addr_d = rf_wr_d ? winAddr : rf_addr_q;
    rf_data_d = rf_wr_d ? winData : rf_data_q;
    ptr_d     = ptr_q;
    for (int i = 1; i < NREQ; i++) begin
      if (grant[i]) ptr_d = (i == NREQ - 1) ? PW'(1) : PW'(i + 1);
    end
    wait_d[0] = '0;
    for (int i = 1; i < NREQ; i++) begin
      if (!req_valid[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + WW'(1);
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      ptr_q     <= PW'(1);
      for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign req_ready = grant;
  assign rf_wr     = rf_wr_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign busy      = (|req_valid) | rf_wr_q;

`ifdef RF_WR_ARB_STATS_EN
  logic [15:0] dropCnt_q, starveCnt_q;

  // Saturating event counters: dropped $0 writes and starvation overrides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropCnt_q   <= '0;
      starveCnt_q <= '0;
    end else begin
      if (accepted && (winAddr == '0) && (dropCnt_q != 16'hFFFF)) begin
        dropCnt_q <= dropCnt_q + 16'd1;
      end
      if (viaStarve && (starveCnt_q != 16'hFFFF)) begin
        starveCnt_q <= starveCnt_q + 16'd1;
      end
    end
  end

  assign stat_drop_cnt   = dropCnt_q;
  assign stat_starve_cnt = starveCnt_q;
`endif

endmodule
